// File: rtl/cordic_vector_enc.sv
// Vectoring-mode CORDIC: rotates (XM,YM) onto the +X axis one micro-rotation per cycle,
// recording each rotation direction in index_cor for a downstream rotation pipeline.
module cordic_vector_enc #(
    parameter int ITER = 10,
    parameter int W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wen_in,
    input  logic signed [W-1:0] XM,
    input  logic signed [W-1:0] YM,
    output logic [ITER-1:0]     index_cor,
    output logic                quad,
    output logic signed [W+1:0] mag,
    output logic signed [W+1:0] yres,
    output logic [3:0]          count,
    output logic                busy,
    output logic                wen_out
);

    // Two guard bits: one absorbs negating -2^(W-1), one absorbs the ~1.647 CORDIC gain.
    localparam int XW = W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [XW-1:0]  x_q, x_d;
    logic signed [XW-1:0]  y_q, y_d;
    logic [ITER-1:0]       idx_q, idx_d;
    logic                  quad_q, quad_d;
    logic [3:0]            count_q, count_d;

    logic signed [XW-1:0]  xm_ext, ym_ext;
    logic signed [XW-1:0]  x_sh, y_sh;
    logic                  load;
    logic                  last_iter;

    assign xm_ext    = {{2{XM[W-1]}}, XM};
    assign ym_ext    = {{2{YM[W-1]}}, YM};
    assign x_sh      = x_q >>> count_q;
    assign y_sh      = y_q >>> count_q;
    assign load      = (state_q == IDLE) && wen_in;
    assign last_iter = (count_q == 4'(ITER - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wen_in)    state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy    = (state_q != IDLE);
        wen_out = (state_q == DONE);
    end

    // Datapath next values: load with half-plane pre-rotation, then one micro-rotation per RUN cycle
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        quad_d  = quad_q;
        count_d = count_q;
        if (load) begin
            if (XM[W-1]) begin
                x_d    = -xm_ext;
                y_d    = -ym_ext;
                quad_d = 1'b1;
            end else begin
                x_d    = xm_ext;
                y_d    = ym_ext;
                quad_d = 1'b0;
            end
            idx_d   = '0;
            count_d = 4'd0;
        end else if (state_q == RUN) begin
            if (y_q[XW-1]) begin
                x_d = x_q - y_sh;
                y_d = y_q + x_sh;
            end else begin
                x_d = x_q + y_sh;
                y_d = y_q - x_sh;
            end
            for (int i = 0; i < ITER; i++) begin
                if (count_q == 4'(i)) idx_d[i] = y_q[XW-1];
            end
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            quad_q  <= 1'b0;
            count_q <= 4'd0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            quad_q  <= quad_d;
            count_q <= count_d;
        end
    end

    assign index_cor = idx_q;
    assign quad      = quad_q;
    assign mag       = x_q;
    assign yres      = y_q;
    assign count     = count_q;

endmodule

// File: tb/tb_cordic_vector_enc.sv
// Directed bench for cordic_vector_enc: hand-traced CORDIC vectors, latency, busy-ignore and reset abort.
module tb_cordic_vector_enc;

    localparam int ITER = 10;
    localparam int W    = 16;
    // wen_in sampled at edge N -> wen_out high in the cycle ending at edge N+ITER+1,
    // i.e. visible right after the ITER-th edge following N.
    localparam int LAT  = ITER;

    logic                clk = 1'b0;
    logic                reset;
    logic                wen_in;
    logic signed [W-1:0] XM, YM;
    logic [ITER-1:0]     index_cor;
    logic                quad;
    logic signed [W+1:0] mag, yres;
    logic [3:0]          count;
    logic                busy, wen_out;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int lat;
    int pulses;

    cordic_vector_enc #(.ITER(ITER), .W(W)) dut (
        .clk(clk), .reset(reset), .wen_in(wen_in), .XM(XM), .YM(YM),
        .index_cor(index_cor), .quad(quad), .mag(mag), .yres(yres),
        .count(count), .busy(busy), .wen_out(wen_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] lo, input logic signed [31:0] hi);
        n_total++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic signed [W-1:0] xm, input logic signed [W-1:0] ym);
        wen_in = 1'b1;
        XM     = xm;
        YM     = ym;
        tick();
        wen_in = 1'b0;
        XM     = '0;
        YM     = '0;
    endtask

    task automatic wait_out(output int l);
        l = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (wen_out) begin
                l = k;
                break;
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        wen_in = 1'b0;
        XM     = '0;
        YM     = '0;
        tick();
        tick();

        chk("rst_busy",    busy,      0);
        chk("rst_wen_out", wen_out,   0);
        chk("rst_count",   count,     0);
        chk("rst_index",   index_cor, 0);
        chk("rst_quad",    quad,      0);
        chk("rst_mag",     mag,       0);
        chk("rst_yres",    yres,      0);
        reset = 1'b1;
        tick();

        // (1000,0): traced by hand -> mag 1648, yres -1, index 0x32E
        start(16'sd1000, 16'sd0);
        chk("a_busy", busy, 1);
        chk("a_count0", count, 0);
        wait_out(lat);
        chk("a_lat", lat, LAT);
        chk("a_index", index_cor, 32'h32E);
        chk("a_quad", quad, 0);
        chk("a_mag", mag, 1648);
        chk("a_yres", yres, -1);
        chk_rng("a_mag_rng", mag, 1643, 1651);
        tick();
        chk("a_pulse_one", wen_out, 0);
        chk("a_idle", busy, 0);
        tick();
        tick();
        chk("a_hold_mag", mag, 1648);
        chk("a_hold_index", index_cor, 32'h32E);

        // (-1000,0): pre-rotated into the same vector as above
        start(-16'sd1000, 16'sd0);
        wait_out(lat);
        chk("b_lat", lat, LAT);
        chk("b_quad", quad, 1);
        chk("b_index", index_cor, 32'h32E);
        chk("b_mag", mag, 1648);
        chk("b_yres", yres, -1);
        tick();

        // (0,1000): mag 1647, yres 1, index 0x0D0
        start(16'sd0, 16'sd1000);
        wait_out(lat);
        chk("c_lat", lat, LAT);
        chk("c_quad", quad, 0);
        chk("c_index", index_cor, 32'h0D0);
        chk("c_mag", mag, 1647);
        chk("c_yres", yres, 1);
        tick();

        // (-32768,-32768): full-scale corner, mag 76311, yres 99, index 0x07C
        start(-16'sd32768, -16'sd32768);
        wait_out(lat);
        chk("d_lat", lat, LAT);
        chk("d_quad", quad, 1);
        chk("d_index", index_cor, 32'h07C);
        chk("d_mag", mag, 76311);
        chk("d_yres", yres, 99);
        chk_rng("d_mag_rng", mag, 76240, 76360);
        tick();

        // (0,0): trivial vector completes with everything zero
        start(16'sd0, 16'sd0);
        wait_out(lat);
        chk("e_lat", lat, LAT);
        chk("e_index", index_cor, 0);
        chk("e_mag", mag, 0);
        chk("e_yres", yres, 0);
        tick();

        // Second start three edges into a run must be ignored
        start(16'sd1000, 16'sd0);
        tick();
        tick();
        wen_in = 1'b1;
        XM     = 16'sd0;
        YM     = 16'sd1000;
        tick();
        wen_in = 1'b0;
        XM     = '0;
        YM     = '0;
        wait_out(lat);
        chk("f_lat", lat, LAT - 3);
        chk("f_index", index_cor, 32'h32E);
        chk("f_mag", mag, 1648);
        chk("f_yres", yres, -1);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (wen_out) pulses++;
        end
        chk("f_no_second", pulses, 0);

        // Reset at count=5 aborts; reset wins over a simultaneous start
        start(16'sd0, 16'sd1000);
        for (int k = 0; k < 5; k++) tick();
        chk("g_count5", count, 5);
        reset  = 1'b0;
        wen_in = 1'b1;
        XM     = 16'sd0;
        YM     = 16'sd1000;
        tick();
        chk("g_busy", busy, 0);
        chk("g_wen_out", wen_out, 0);
        chk("g_count", count, 0);
        chk("g_index", index_cor, 0);
        chk("g_mag", mag, 0);
        chk("g_yres", yres, 0);
        reset = 1'b1;
        tick();
        wen_in = 1'b0;
        XM     = '0;
        YM     = '0;
        chk("g_accept", busy, 1);
        wait_out(lat);
        chk("g_lat", lat, LAT);
        chk("g_index2", index_cor, 32'h0D0);
        chk("g_mag2", mag, 1647);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cordic_vector_enc.md
CORDIC_VECTOR_ENC -- requirements
Module: cordic_vector_enc

Interface
REQ-001 SHALL have parameter ITER, default 10, meaning number of micro-rotations and width of index_cor.
REQ-002 SHALL have parameter W, default 16, meaning input sample width (signed two's complement).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 wen_in  input  1  start strobe; XM/YM valid when high.
REQ-006 XM  input  16  signed X of input vector.
REQ-007 YM  input  16  signed Y of input vector.
REQ-008 index_cor  output  10  direction bits; bit i is the decision of iteration i, consumed by the rotation pipeline.
REQ-009 quad  output  1  1 = input had X<0 and was pre-rotated by 180 degrees.
REQ-010 mag  output  18  signed final X (magnitude times CORDIC gain, approximately 1.647).
REQ-011 yres  output  18  signed final Y residual.
REQ-012 count  output  4  current iteration index.
REQ-013 busy  output  1  high while not in IDLE.
REQ-014 wen_out  output  1  one-cycle pulse; index_cor/quad/mag/yres valid.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: wen_in=1 SHALL load X,Y sign-extended to 18 bits, clear index_cor, set count=0, and enter RUN.
REQ-017 Load pre-rotation: X<0 SHALL load X=-XM, Y=-YM, quad=1; otherwise X=XM, Y=YM, quad=0; XM=-32768 SHALL negate without overflow (18-bit).
REQ-018 RUN, iteration i=count: Y>=0 SHALL give index_cor[i]=0, X<=X+(Y>>>i), Y<=Y-(X>>>i).
REQ-019 RUN, iteration i: Y<0 SHALL give index_cor[i]=1, X<=X-(Y>>>i), Y<=Y+(X>>>i).
REQ-020 Shifts SHALL be arithmetic and use the pre-update X,Y; results SHALL be truncated, no rounding, no saturation.
REQ-021 count SHALL increment each RUN cycle; after iteration ITER-1, FSM SHALL enter DONE.
REQ-022 DONE SHALL assert wen_out for exactly one cycle and return to IDLE.
REQ-023 Latency SHALL be fixed: wen_in sampled at edge N gives wen_out high in cycle N+ITER+1 (11 for default).
REQ-024 wen_in while busy=1 (RUN or DONE) SHALL be ignored; no queuing; in-flight operation SHALL be unaffected.
REQ-025 index_cor, quad, mag, yres SHALL hold their values after DONE until the next accepted wen_in.
REQ-026 Back-to-back throughput: next start SHALL be accepted no earlier than the IDLE cycle following DONE.
REQ-027 XM=YM=0 SHALL complete normally with index_cor=0, mag=0, yres=0.

Reset
REQ-028 reset=0 at a clock edge SHALL force IDLE, count=0, index_cor=0, quad=0, mag=0, yres=0, busy=0, wen_out=0.
REQ-029 Reset mid-RUN SHALL abort the operation without wen_out; the first cycle after release SHALL accept wen_in.
REQ-030 Reset SHALL take priority over wen_in in the same cycle.

Verification
REQ-031 XM=1000, YM=0 -> wen_out after 11 cycles; index_cor[0]=0, index_cor[1]=1; quad=0; mag within 1647+/-4; |yres|<=4.
REQ-032 XM=-1000, YM=0 -> quad=1; index_cor and mag identical to REQ-031 case.
REQ-033 XM=0, YM=1000 -> index_cor[0]=0, index_cor[1]=0; quad=0; mag within 1647+/-4.
REQ-034 XM=-32768, YM=-32768 -> quad=1, no overflow; mag within 76300+/-60 (in range); |yres| small.
REQ-035 Second wen_in 3 cycles after the first -> ignored; single wen_out at cycle 11 carrying the first result only.
REQ-036 reset=0 at RUN count=5 -> all outputs zero next cycle; no wen_out; a new wen_in completes in 11 cycles.
